// File: rtl/fir_slice_mac.sv
// Programmable FIR with slice-serial input and one time-shared MAC.
// Define FIR_SAT_EN to saturate the output instead of wrapping.
module fir_slice_mac #(
  parameter int DW   = 8,
  parameter int NW   = 4,
  parameter int CW   = 16,
  parameter int FRAC = 12,
  parameter int TAPS = 16,
  parameter int OW   = 8,
  localparam int TW  = $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          x_valid,
  input  logic [NW-1:0] x_slice,
  output logic          x_ready,
  input  logic          coef_we,
  input  logic [TW-1:0] coef_addr,
  input  logic [CW-1:0] coef_data,
  output logic          z_valid,
  output logic [OW-1:0] z,
  output logic          busy
);

  localparam int NS = DW / NW;
  localparam int KW = (NS > 1) ? $clog2(NS) : 1;
  localparam int AW = DW + CW + TW;

  localparam logic signed [AW:0] ZMAX =
    {{(AW + 2 - OW){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic signed [AW:0] ZMIN = ~ZMAX;
  localparam logic signed [AW:0] HALF =
    (AW + 1)'(1) << (FRAC - 1);

  typedef enum logic [1:0] {GATHER, MAC, OUT} state_t;

  state_t state;

  logic        [KW-1:0]   k;
  logic        [TW-1:0]   t;
  logic        [DW-1:0]   sample_q;
  logic        [DW-1:0]   sample_full;
  logic signed [DW-1:0]   d [TAPS];
  logic signed [CW-1:0]   c [TAPS];
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   acc_nxt;
  logic signed [DW+CW-1:0] prod;
  logic signed [AW:0]     rsum;
  logic signed [AW:0]     r;
  logic        [OW-1:0]   z_nxt;
  logic                   k_last;
  logic                   t_last;
  logic                   unused_r;

  assign x_ready = (state == GATHER);
  assign busy    = (state != GATHER);
  assign k_last  = (k == KW'(NS - 1));
  assign t_last  = (t == TW'(TAPS - 1));

  always_comb begin
    sample_full = sample_q;
    sample_full[k*NW +: NW] = x_slice;
  end

  assign prod    = d[t] * c[t];
  assign acc_nxt = acc + prod;
  // Round half up on the final sum, including the last tap product.
  assign rsum    = {acc_nxt[AW-1], acc_nxt} + HALF;
  assign r       = rsum >>> FRAC;
  assign unused_r = ^r;

  always_comb begin
`ifdef FIR_SAT_EN
    if (r > ZMAX)
      z_nxt = ZMAX[OW-1:0];
    else if (r < ZMIN)
      z_nxt = ZMIN[OW-1:0];
    else
      z_nxt = r[OW-1:0];
`else
    z_nxt = r[OW-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= GATHER;
      k        <= '0;
      t        <= '0;
      acc      <= '0;
      sample_q <= '0;
      z        <= '0;
      z_valid  <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        d[i] <= '0;
        c[i] <= '0;
      end
    end else begin
      z_valid <= 1'b0;
      if (coef_we && state == GATHER &&
          int'(coef_addr) < TAPS)
        c[coef_addr] <= coef_data;
      unique case (state)
        GATHER: begin
          if (x_valid) begin
            sample_q <= sample_full;
            if (k_last) begin
              k <= '0;
              for (int i = TAPS - 1; i > 0; i--)
                d[i] <= d[i-1];
              d[0]  <= sample_full;
              acc   <= '0;
              t     <= '0;
              state <= MAC;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        MAC: begin
          acc <= acc_nxt;
          t   <= t + TW'(1);
          if (t_last) begin
            z     <= z_nxt;
            state <= OUT;
          end
        end
        OUT: begin
          z_valid <= 1'b1;
          state   <= GATHER;
        end
        default: state <= GATHER;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_slice_mac.sv
// Scoreboard bench for fir_slice_mac with hand-computed vectors.
// Expected results are queued at issue and checked by a monitor.
module tb_fir_slice_mac;

  logic        clk = 1'b0;
  logic        reset;
  logic        x_valid;
  logic [3:0]  x_slice;
  logic        x_ready;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [15:0] coef_data;
  logic        z_valid;
  logic [7:0]  z;
  logic        busy;

  logic [7:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  logic [15:0] imp_c[16] = '{
    16'hFFF8, 16'h0010, 16'h0020, 16'hFFA0,
    16'hFF40, 16'h0140, 16'h0280, 16'hF800,
    16'h0800, 16'hFD80, 16'hFEC0, 16'h00C0,
    16'h0060, 16'hFFE0, 16'hFFF0, 16'h0008};
  logic [7:0] imp_z[16] = '{
    8'h00, 8'h00, 8'h00, 8'h00,
    8'hFF, 8'h01, 8'h03, 8'hF8,
    8'h08, 8'hFE, 8'hFF, 8'h01,
    8'h00, 8'h00, 8'h00, 8'h00};

  fir_slice_mac dut (
    .clk      (clk),
    .reset    (reset),
    .x_valid  (x_valid),
    .x_slice  (x_slice),
    .x_ready  (x_ready),
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .z_valid  (z_valid),
    .z        (z),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [7:0] e;
    if (!reset && z_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_z: z=%h with none pending", z);
      end else begin
        e = exp_q.pop_front();
        if (z !== e) begin
          bad++;
          $display("FAIL z_result: got %h want %h", z, e);
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] got,
                     logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!x_ready && n < 100) begin
      step();
      n++;
    end
    if (!x_ready) chk("x_ready_timeout", {31'd0, x_ready}, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    if (busy) chk("idle_timeout", {31'd0, busy}, 0);
  endtask

  task automatic feed(input logic [7:0] s);
    for (int i = 0; i < 2; i++) begin
      wait_ready();
      x_valid = 1'b1;
      x_slice = s[i*4 +: 4];
      step();
      x_valid = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] s, input logic [7:0] e);
    exp_q.push_back(e);
    feed(s);
  endtask

  task automatic wr_raw(input logic [3:0] a, input logic [15:0] v);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = v;
    step();
    coef_we   = 1'b0;
  endtask

  task automatic wr_coef(input logic [3:0] a, input logic [15:0] v);
    wait_idle();
    wr_raw(a, v);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    x_valid   = 1'b0;
    x_slice   = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    repeat (3) step();
    reset = 1'b0;

    chk("rst_z_valid", {31'd0, z_valid}, 0);
    chk("rst_z", {24'd0, z}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_x_ready", {31'd0, x_ready}, 1);

    wr_coef(4'd0, 16'h1000);
    send(8'h25, 8'h25);
    n = 0;
    do begin
      step();
      n++;
    end while (!z_valid && n < 40);
    chk("latency", n, 17);

    wr_coef(4'd0, 16'h0800);
    send(8'h03, 8'h02);
    send(8'hFD, 8'hFF);

    wr_coef(4'd0, 16'h7FFF);
`ifdef FIR_SAT_EN
    send(8'h7F, 8'h7F);
`else
    send(8'h7F, 8'hF8);
`endif

    wr_coef(4'd0, 16'h1000);
    send(8'h25, 8'h25);
    chk("busy_in_mac", {31'd0, busy}, 1);
    wr_raw(4'd0, 16'h0000);
    send(8'h11, 8'h11);
    drain();

    feed(8'h44);
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midmac_z", {24'd0, z}, 0);
    chk("midmac_x_ready", {31'd0, x_ready}, 1);
    chk("midmac_busy", {31'd0, busy}, 0);
    chk("midmac_z_valid", {31'd0, z_valid}, 0);
    repeat (25) step();
    send(8'h33, 8'h00);
    drain();

    pulse_reset();
    for (int i = 0; i < 16; i++)
      wr_coef(4'(i), imp_c[i]);
    send(8'h10, imp_z[0]);
    for (int i = 1; i < 16; i++)
      send(8'h00, imp_z[i]);
    drain();

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
